// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller states and small decode helpers.
package mdu_pkg;

  // Operation codes carried on mdu_op.
  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MTHI     = 4'd5,
    MTLO     = 4'd6,
    MFHI     = 4'd7,
    MFLO     = 4'd8
  } mdu_op_e;

  // Controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int DATA_W = 32;

  // True for the multi-cycle operations that occupy the unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // True for the divide class (selects the divide latency).
  function automatic logic is_div(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Works only from the operands and
// op class latched at issue, so the result is stable for the whole busy window.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res,
  output logic              div_by_zero
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic                div_signed;
  logic                neg_a;
  logic                neg_b;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W-1:0]   quo_u;
  logic [DATA_W-1:0]   rem_u;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  // Products: the low 64 bits of a sign-extended multiply equal the signed
  // product, so both flavours use the same unsigned multiply operator.
  always_comb begin
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  end

  // Signed divide via magnitudes: truncating quotient, remainder takes the
  // dividend's sign. The magnitude of 0x80000000 is 0x80000000 as unsigned,
  // which makes 0x80000000 / -1 come out as lo=0x80000000, hi=0 naturally.
  always_comb begin
    div_signed  = (op == DIV);
    neg_a       = div_signed && a[DATA_W-1];
    neg_b       = div_signed && b[DATA_W-1];
    mag_a       = neg_a ? (~a + 1'b1) : a;
    mag_b       = neg_b ? (~b + 1'b1) : b;
    div_by_zero = is_div(op) && (b == '0);
    quo_u       = '0;
    rem_u       = '0;
    if (b != '0) begin
      quo_u = mag_a / mag_b;
      rem_u = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? (~quo_u + 1'b1) : quo_u;
    rem = neg_a ? (~rem_u + 1'b1) : rem_u;
  end

  // Result select by op class.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    hi_res = '0;
    lo_res = '0;
    unique case (op)
      MULT: begin
        hi_res = prod_s[2*DATA_W-1:DATA_W];
        lo_res = prod_s[DATA_W-1:0];
      end
      MULTU: begin
        hi_res = prod_u[2*DATA_W-1:DATA_W];
        lo_res = prod_u[DATA_W-1:0];
      end
      DIV, DIVU: begin
        hi_res = rem;
        lo_res = quo;
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the execute stage. Owns HI/LO,
// sequences fixed-latency MULT/DIV, serves MTHI/MTLO writes and MFHI/MFLO reads,
// and exposes a registered busy for the stall logic.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        busy,
  output logic [31:0] mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV   = CNT_W'(DIV_CYCLES);

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic [3:0]        op_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;

  logic [31:0]       hi_res;
  logic [31:0]       lo_res;
  logic              div_by_zero;

  mdu_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  // FSM: accept issue in IDLE, count down in RUN, commit HI/LO on the last edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (is_muldiv(mdu_op)) begin
              op_q    <= mdu_op;
              a_q     <= data1;
              b_q     <= data2;
              cnt_q   <= is_div(mdu_op) ? CNT_DIV : CNT_MULT;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else if (mdu_op == MTHI) begin
              hi_q <= data1;
            end else if (mdu_op == MTLO) begin
              lo_q <= data1;
            end
          end
        end
        RUN: begin
          // Any start here is dropped; the stall unit keeps it from happening.
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            // A zero divisor still takes the full latency but leaves HI/LO alone.
            if (!div_by_zero) begin
              hi_q <= hi_res;
              lo_q <= lo_res;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read port: MFHI/MFLO return the live registers, anything else reads zero.
  always_comb begin
    mdu_out = '0;
    if (mdu_op == MFHI) begin
      mdu_out = hi_q;
    end else if (mdu_op == MFLO) begin
      mdu_out = lo_q;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a table of directed operations with
// hand-computed HI/LO and busy lengths, plus sequences for reset abort,
// issue-while-busy, operand changes after issue and back-to-back issue.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int BOUND  = 200;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .data1   (data1),
    .data2   (data2),
    .busy    (busy),
    .mdu_out (mdu_out),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge: present one start pulse, return at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
    mdu_op = op;
    data1  = d1;
    data2  = d2;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = MDU_NONE;
  endtask

  // Count negedges with busy high, bounded; ends at the first negedge with busy low.
  task automatic count_busy(input int already, output int n);
    n = already;
    while (busy === 1'b1 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check("busy_settles", {31'b0, busy}, 32'd0);
  endtask

  task automatic read_back(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mdu_op = MFHI;
    #1;
    check({tag, "_mfhi"}, mdu_out, exp_hi);
    mdu_op = MFLO;
    #1;
    check({tag, "_mflo"}, mdu_out, exp_lo);
    mdu_op = MDU_NONE;
    #1;
    check({tag, "_none_out"}, mdu_out, 32'd0);
  endtask

  initial begin
    int n;

    vecs[0]  = '{MULT,     32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MULT_N};
    vecs[1]  = '{MULTU,    32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, MULT_N};
    vecs[2]  = '{DIV,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
    vecs[3]  = '{DIV,      32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_N};
    vecs[4]  = '{MTHI,     32'h00000011, 32'h0,        32'h00000011, 32'h80000000, 0};
    vecs[5]  = '{MTLO,     32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0};
    vecs[6]  = '{DIVU,     32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, DIV_N};
    vecs[7]  = '{DIV,      32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, DIV_N};
    vecs[8]  = '{DIVU,     32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DIV_N};
    vecs[9]  = '{DIV,      32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_N};
    vecs[10] = '{DIV,      32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DIV_N};
    vecs[11] = '{MULT,     32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_N};
    vecs[12] = '{MULTU,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULT_N};
    vecs[13] = '{MULT,     32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MULT_N};
    vecs[14] = '{MFHI,     32'hDEADBEEF, 32'h12345678, 32'h00000001, 32'h00000000, 0};
    vecs[15] = '{4'hF,     32'hDEADBEEF, 32'h12345678, 32'h00000001, 32'h00000000, 0};

    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = MDU_NONE;
    data1  = '0;
    data2  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    read_back("rst", 32'd0, 32'd0);

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].d1, vecs[i].d2);
      count_busy(0, n);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].exp_cyc);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      read_back($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Operands change and MTHI is pulsed while a MULT is in flight.
    issue(MULT, 32'd3, 32'd4);
    data1  = 32'h55;
    data2  = 32'h66;
    mdu_op = MTHI;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = MDU_NONE;
    count_busy(1, n);
    check("latch_cycles", n, MULT_N);
    check("latch_hi", hi, 32'd0);
    check("latch_lo", lo, 32'd12);

    // Back-to-back: issue in the first cycle busy is low again.
    issue(MULT, 32'd2, 32'd3);
    count_busy(0, n);
    check("b2b_first_lo", lo, 32'd6);
    issue(MULT, 32'd4, 32'd5);
    check("b2b_busy_rises", {31'b0, busy}, 32'd1);
    mdu_op = MFLO;
    #1;
    check("b2b_mflo_old", mdu_out, 32'd6);
    mdu_op = MDU_NONE;
    @(negedge clk);
    count_busy(1, n);
    check("b2b_cycles", n, MULT_N);
    check("b2b_second_lo", lo, 32'd20);
    check("b2b_second_hi", hi, 32'd0);

    // Reset in the middle of a DIV discards the result.
    issue(MTHI, 32'hAA, 32'd0);
    issue(DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (DIV_N + 2) @(negedge clk);
    check("abort_hi_later", hi, 32'd0);
    check("abort_lo_later", lo, 32'd0);
    check("abort_busy_later", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
